bram_stream_reader: RTL
=======================

// Module: bram_stream_reader
// PURPOSE
//  Read-side master for the 64Kx16 single-port write-first block RAM. On a start
//  command it streams LEN words beginning at BASE out of the RAM.
//  Output is a valid/ready stream, so a UART/VGA/display consumer can drain a frame buffer.
//  It absorbs the RAM's 1-cycle registered read latency with a 2-entry output FIFO
//  and sustains 1 word/clk when m_ready stays high.
// PARAMETERS
//  ADDR_W   16  RAM address width; addresses wrap modulo 2**ADDR_W
//  DATA_W   16  RAM / stream data width
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       1-clk command pulse; sampled only when busy==0
//  base_addr  in   ADDR_W  first word address, captured on accepted start
//  len        in   ADDR_W  word count, captured on accepted start; 0 = no-op
//  busy       out  1       high from accepted start until the last word is accepted
//  done       out  1       1-clk pulse when the transfer completes
//  ram_en     out  1       RAM enable; high only on a read issue
//  ram_we     out  1       RAM write enable; constant 0
//  ram_addr   out  ADDR_W  RAM address
//  ram_dout   in   DATA_W  RAM registered read data; valid the clk after issue
//  m_data     out  DATA_W  stream data
//  m_valid    out  1       stream valid
//  m_last     out  1       high with the final word of a transfer
//  m_ready    in   1       stream ready; a word transfers when m_valid&m_ready
// BEHAVIOUR
//  Reset: all outputs are 0 (busy, done, ram_en, ram_we, ram_addr, m_data, m_valid, m_last).
//   FIFO is emptied, pending flag cleared, FSM returns to IDLE. Reset applies
//   immediately, mid-transfer included; data in flight is discarded.
//  FSM:
//   IDLE -> RUN on start with len!=0. Captures addr<=base_addr, issue_cnt<=len, out_cnt<=len.
//   IDLE -> IDLE on start with len==0. done pulses the next clk and busy stays 0.
//   RUN  -> DRAIN when the last read is issued (issue_cnt reaches 0).
//   DRAIN -> IDLE when the word with m_last is accepted. done pulses that same edge (registered).
//   start while busy is ignored.
//  Issue rule (comb): issue = RUN & (issue_cnt!=0) & (fifo_cnt + pend < 2 | (m_valid & m_ready)).
//   On issue: ram_en=1, ram_addr=addr. Then addr<=addr+1 (0xFFFF wraps to 0x0000),
//   issue_cnt<=issue_cnt-1, pend<=1; with no issue, pend<=0.
//  Capture: when pend==1, ram_dout is pushed into the FIFO that edge.
//   The RAM updates dout every clk regardless of en, so capture must happen exactly
//   one clk after issue. No other timing is legal.
//  FIFO: depth 2, first-word-fall-through. m_valid = fifo_cnt!=0.
//   A push and a pop in the same clk keep the count. The issue rule guarantees no overflow.
//  m_last = m_valid & (out_cnt==1). out_cnt decrements on every accepted word.
//  Latency: start -> first m_valid = 3 clks (capture edge, issue, RAM read, FIFO push).
//  Throughput: 1 word/clk with m_ready held high. Stalls of any length lose no data.
//  ram_addr holds its last value when ram_en==0.
// STRUCTURE
//  Shared header bram_defs.vh: ADDR_W/DATA_W defaults and FSM encodings
//   S_IDLE=2'd0, S_RUN=2'd1, S_DRAIN=2'd2.
//  Sub-module bram_rd_fifo: 2-entry FWFT FIFO with push/pop/count, async rst.
//  Top level holds the FSM, counters, issue logic and pend flag.
// TESTING (bench contains a behavioural copy of the write-first RAM, preloaded RAM[i]=i^16'hA5A5)
//  base=0x0010, len=4, m_ready=1 -> words 0xA5B5,0xA5B4,0xA5B7,0xA5B6 on 4 consecutive clks;
//   m_last on the 4th word; done 1 clk later; busy low.
//  base=0xFFFE, len=3 -> addresses 0xFFFE,0xFFFF,0x0000; data 0x5A5B,0x5A5A,0xA5A5.
//  len=8, m_ready toggling 1/0 every clk plus a 10-clk low hold -> all 8 words in order,
//   no duplicates or drops, ram_en never issued when fifo_cnt+pend==2 without a pop.
//  start with len=0 -> busy stays 0, done pulses once, ram_en never asserted.
//  rst asserted 2 clks into a len=16 transfer -> all outputs 0 asynchronously.
//   Then a fresh start base=0x0000,len=2 -> 0xA5A5,0xA5A4 and nothing stale.
//  start pulsed again while busy -> ignored; original transfer completes unaltered.

Source files
------------

// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the block-RAM stream reader: default widths,
// FSM encoding and the read-issue room test.
package bram_stream_reader_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // A read may be issued when the words already owed to the FIFO (stored plus
  // the one in the RAM pipeline) leave a free slot, or a pop frees one this clk.
  function automatic logic fifo_has_room(input logic [1:0] cnt,
                                         input logic       pend,
                                         input logic       pop);
    return ((({1'b0, cnt}) + {2'b00, pend}) < 3'd2) || pop;
  endfunction

endpackage

// File: rtl/bram_rd_fifo.sv
// Two-entry first-word-fall-through FIFO sitting between the RAM read port
// and the output stream. The head word is always visible on pop_data.
module bram_rd_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_reg [2];
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [1:0]        count_reg;

  // Storage, pointers and occupancy; a simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign pop_data = mem_reg[rd_ptr_reg];
  assign count    = count_reg;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams LEN consecutive words out of a single-port block RAM as a
// valid/ready stream. The RAM's one-clock read latency is hidden by a
// two-entry FIFO, so the stream runs at one word per clock when not stalled.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] last_addr_reg;
  logic [ADDR_W-1:0] issue_cnt_reg;
  logic [ADDR_W-1:0] out_cnt_reg;
  logic              pend_reg;
  logic              done_reg;
  logic              done_next;
  logic              issue;
  logic              accept;
  logic              start_run;
  logic [1:0]        fifo_cnt;

  assign m_valid   = (fifo_cnt != 2'd0);
  assign accept    = m_valid & m_ready;
  assign start_run = (state_reg == S_IDLE) & start & (len != '0);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: run until the last read is issued, then drain until the last word leaves.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start_run) state_next = S_RUN;
      S_RUN:   if (issue && (issue_cnt_reg == ONE)) state_next = S_DRAIN;
      S_DRAIN: if (accept && (out_cnt_reg == ONE)) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM outputs: busy, read issue and the completion strobe to be registered.
  always_comb begin
    busy      = 1'b0;
    issue     = 1'b0;
    done_next = 1'b0;
    case (state_reg)
      S_IDLE: begin
        done_next = start & (len == '0);
      end
      S_RUN: begin
        busy  = 1'b1;
        issue = (issue_cnt_reg != '0) && fifo_has_room(fifo_cnt, pend_reg, accept);
      end
      S_DRAIN: begin
        busy      = 1'b1;
        done_next = accept & (out_cnt_reg == ONE);
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Address and word counters: loaded on an accepted start, stepped per issue / per accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg      <= '0;
      last_addr_reg <= '0;
      issue_cnt_reg <= '0;
      out_cnt_reg   <= '0;
    end else if (start_run) begin
      addr_reg      <= base_addr;
      issue_cnt_reg <= len;
      out_cnt_reg   <= len;
    end else begin
      if (issue) begin
        addr_reg      <= addr_reg + ONE;
        last_addr_reg <= addr_reg;
        issue_cnt_reg <= issue_cnt_reg - ONE;
      end
      if (accept) begin
        out_cnt_reg <= out_cnt_reg - ONE;
      end
    end
  end

  // Pending flag marks that the RAM output must be captured on the very next edge; done is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      pend_reg <= issue;
      done_reg <= done_next;
    end
  end

  bram_rd_fifo #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (pend_reg),
    .push_data(ram_dout),
    .pop      (accept),
    .pop_data (m_data),
    .count    (fifo_cnt)
  );

  // The RAM address shows the issued address while enabled and otherwise holds the last one.
  assign ram_en   = issue;
  assign ram_we   = 1'b0;
  assign ram_addr = issue ? addr_reg : last_addr_reg;
  assign done     = done_reg;
  assign m_last   = m_valid & (out_cnt_reg == ONE);

endmodule
